// File: rtl/spram_ctrl_if.sv
// Requester A/B handshake plus single-port RAM bus for spram_ctrl.
// slave: the controller side; master: requesters + RAM model side.
interface spram_ctrl_if;
  logic        a_req;
  logic        a_we;
  logic [4:0]  a_addr;
  logic [15:0] a_wdata;
  logic        a_gnt;
  logic        a_rvalid;
  logic [15:0] a_rdata;

  logic        b_req;
  logic        b_we;
  logic [4:0]  b_addr;
  logic [15:0] b_wdata;
  logic        b_gnt;
  logic        b_rvalid;
  logic [15:0] b_rdata;

  logic        ram_r_w;
  logic [4:0]  ram_addr;
  logic [15:0] ram_d_in;
  logic [15:0] ram_d_out;
  logic        init_done;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output ram_r_w, ram_addr, ram_d_in, init_done,
    input  ram_d_out
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  ram_r_w, ram_addr, ram_d_in, init_done,
    output ram_d_out
  );
endinterface

// File: rtl/spram_ctrl.sv
// Two-requester round-robin controller for a 32x16 single-port RAM.
// Zero-wait grant, one transfer per cycle, registered RAM command,
// read data returned two cycles after the accepting edge.
// Optional macro SPRAM_CTRL_INIT_EN: zero-fill sweep of all 32 words
// after every reset before requests are accepted.
module spram_ctrl (
  input  logic        clk,
  input  logic        rst,
  spram_ctrl_if.slave bus
);
  localparam int NUM_REQ = 2;
  localparam int STAGES  = 2;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [15:0] wdata;
  } cmd_t;

  typedef enum logic { INIT, RUN } state_t;

  state_t                    state;
  logic                      rr_b;      // 1: B wins the next contention
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        gnt;
  cmd_t [NUM_REQ-1:0]        cmd;
  cmd_t                      sel_cmd;
  logic                      accept;
  logic                      acc_b;
  logic [STAGES:1]           vld_pipe;  // read in flight
  logic [STAGES:1]           own_pipe;  // 1: read belongs to B
  logic                      ram_r_w_q;
  logic [4:0]                ram_addr_q;
  logic [15:0]               ram_d_in_q;
  logic                      init_done_q;
`ifdef SPRAM_CTRL_INIT_EN
  logic [4:0]                sweep_cnt;
`endif

  assign req    = {bus.b_req, bus.a_req};
  assign cmd[0] = '{we: bus.a_we, addr: bus.a_addr, wdata: bus.a_wdata};
  assign cmd[1] = '{we: bus.b_we, addr: bus.b_addr, wdata: bus.b_wdata};

  // Arbitration: sole requester wins at once, contention goes to rr_b.
  always_comb begin
    gnt = '0;
    if (state == RUN) begin
      if (req[0] && (!req[1] || !rr_b)) gnt[0] = 1'b1;
      else if (req[1])                  gnt[1] = 1'b1;
    end
  end

  assign accept  = |gnt;
  assign acc_b   = gnt[1];
  assign sel_cmd = acc_b ? cmd[1] : cmd[0];

  // Main FSM: init sweep, command register, round-robin pointer, read pipe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= INIT;
      rr_b        <= 1'b0;
      ram_r_w_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_d_in_q  <= '0;
      init_done_q <= 1'b0;
      vld_pipe    <= '0;
      own_pipe    <= '0;
`ifdef SPRAM_CTRL_INIT_EN
      sweep_cnt   <= '0;
`endif
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:1], accept && !sel_cmd.we};
      own_pipe  <= {own_pipe[STAGES-1:1], acc_b};
      ram_r_w_q <= 1'b0;
      case (state)
        INIT: begin
`ifdef SPRAM_CTRL_INIT_EN
          ram_r_w_q  <= 1'b1;
          ram_addr_q <= sweep_cnt;
          ram_d_in_q <= '0;
          sweep_cnt  <= sweep_cnt + 5'd1;
          if (sweep_cnt == 5'd31) begin
            state       <= RUN;
            init_done_q <= 1'b1;
          end
`else
          state       <= RUN;
          init_done_q <= 1'b1;
`endif
        end
        RUN: begin
          if (accept) begin
            ram_r_w_q  <= sel_cmd.we;
            ram_addr_q <= sel_cmd.addr;
            ram_d_in_q <= sel_cmd.wdata;
            rr_b       <= !acc_b;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  assign bus.a_gnt     = gnt[0];
  assign bus.b_gnt     = gnt[1];
  assign bus.a_rvalid  = vld_pipe[STAGES] && !own_pipe[STAGES];
  assign bus.b_rvalid  = vld_pipe[STAGES] &&  own_pipe[STAGES];
  assign bus.a_rdata   = bus.ram_d_out;
  assign bus.b_rdata   = bus.ram_d_out;
  assign bus.ram_r_w   = ram_r_w_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_d_in  = ram_d_in_q;
  assign bus.init_done = init_done_q;
endmodule
